wb_pipe: RTL
============

// Module: wb_pipe
// PURPOSE
//  Parametrised write-back stage for the Beta pipeline. Holds one retiring instruction with a
//  valid/ready handshake toward MEM and selects the register-file write source: ALU y, load data
//  or link pc. Load data may arrive any number of cycles late; the stage holds the instruction
//  and back-pressures upstream until it arrives. A wait timeout flags a hung memory.
// PARAMETERS
//  DW        32  datapath width (pc, y, mem_rdata, rf_w_data)
//  RA_W      5   register address width (rc = ir[21+RA_W-1:21])
//  ZERO_REG  31  register index whose writes are suppressed
//  MAX_WAIT  16  cycles spent in WAIT_MEM before mem_err (>=1)
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst_n      in   1     synchronous active-low reset
//  in_valid   in   1     MEM stage presents pc/ir/y
//  in_ready   out  1     stage accepts on in_valid&&in_ready
//  pc         in   DW    link value (pc+4) for JMP/BEQ/BNE
//  ir         in   32    instruction
//  y          in   DW    ALU result / address
//  mem_rvalid in   1     load data valid
//  mem_rdata  in   DW    load data
//  rf_we      out  1     reg file write enable
//  rf_w_addr  out  RA_W  reg file write address
//  rf_w_data  out  DW    reg file write data
//  ir_next    out  32    held ir (for bypass/hazard logic)
//  busy       out  1     stage holds an instruction
//  mem_err    out  1     sticky load timeout
// BEHAVIOUR
//  Decode (op=ir[31:26]): op[5]=1 ALU->y; LD 011000/LDR 011111->mem_rdata;
//   JMP 011011/BEQ 011100/BNE 011101->pc; ST 011001 and all other opcodes: no write.
//  States: EMPTY, ACTIVE, WAIT_MEM, ERR. Stage regs pc_q/ir_q/y_q load on accept only.
//  complete = (ACTIVE && (!is_ld || mem_rvalid)) || (WAIT_MEM && mem_rvalid).
//  in_ready = EMPTY || complete (accept new instr in same cycle old one retires; no bubble).
//  rf_we = complete && writes && rc!=ZERO_REG; rf_w_data per decode, 0 when rf_we=0.
//  Transitions: EMPTY->ACTIVE on accept. ACTIVE: complete&&accept->ACTIVE; complete->EMPTY;
//   load w/o rvalid->WAIT_MEM (wait_cnt=1). WAIT_MEM: rvalid->ACTIVE/EMPTY as above;
//   else wait_cnt++; wait_cnt==MAX_WAIT -> ERR. ERR: in_ready=0, rf_we=0, until reset.
//  mem_rvalid outside a pending load (EMPTY, non-load ACTIVE, ERR) is ignored.
//  Each instruction writes at most once; write is combinational in its completing cycle.
//  Reset (rst_n=0 at edge): state EMPTY, stage regs 0, wait_cnt 0, mem_err 0. While rst_n=0,
//   in_ready=0, rf_we=0. Reset mid-WAIT_MEM drops the load; no write ever issued for it.
//  Outputs after reset: in_ready=1, rf_we=0, rf_w_addr=0, rf_w_data=0, busy=0, mem_err=0.
//  wait_cnt width $clog2(MAX_WAIT+1); saturates at MAX_WAIT.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined: extra port retire_cnt out 32, counts completing instructions
//   (incl. ST and ZERO_REG writes), wraps 0xFFFFFFFF->0, cleared by reset, frozen in ERR.
//  Undefined: port and counter absent; all other behaviour identical.
// TESTING
//  ADD rc=1, y=0x1234 accepted -> next cycle rf_we=1, addr=1, data=0x1234; in_ready stays 1.
//  LD rc=2, mem_rvalid 3 cycles late w/ 0xDEADBEEF -> in_ready=0 for 3 cycles, one write of
//   0xDEADBEEF to r2 in rvalid cycle, back-to-back instr accepted same cycle.
//  ST then BEQ rc=31 pc=0x100 -> rf_we=0 both; retire_cnt +2 when WB_RETIRE_CNT_EN.
//  JMP rc=28 pc=0x204 -> rf_w_data=0x204; stray mem_rvalid same cycle ignored.
//  LD, no rvalid, MAX_WAIT=16 -> mem_err=1 after 16 wait cycles, in_ready=0 until rst_n.
//  rst_n=0 one cycle during WAIT_MEM, rvalid next cycle -> no write, state EMPTY, in_ready=1.

Source files
------------

// File: rtl/wb_pipe_if.sv
// Bundle of the wb_pipe MEM-side handshake, load-return and register-file write signals.
// master = upstream MEM stage / test driver, slave = wb_pipe.
interface wb_pipe_if #(
    parameter int unsigned DW   = 32,
    parameter int unsigned RA_W = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   pc;
    logic [31:0]     ir;
    logic [DW-1:0]   y;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            rf_we;
    logic [RA_W-1:0] rf_w_addr;
    logic [DW-1:0]   rf_w_data;
    logic [31:0]     ir_next;
    logic            busy;
    logic            mem_err;

    modport master (
        output in_valid, pc, ir, y, mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_w_addr, rf_w_data, ir_next, busy, mem_err
    );

    modport slave (
        input  in_valid, pc, ir, y, mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_w_addr, rf_w_data, ir_next, busy, mem_err
    );
endinterface

// File: rtl/wb_pipe.sv
// Beta write-back stage: holds one retiring instruction, waits for late load data, selects the
// register-file write source. Define WB_RETIRE_CNT_EN to add the retire_cnt output.
module wb_pipe #(
    parameter int unsigned DW       = 32,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned MAX_WAIT = 16
) (
    input logic      clk,
    input logic      rst_n,
    wb_pipe_if.slave bus
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);
    localparam int unsigned CW = $clog2(MAX_WAIT + 1);

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StActive  = 2'd1;
    localparam logic [1:0] StWaitMem = 2'd2;
    localparam logic [1:0] StErr     = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [DW-1:0]   pc_q, y_q;
    logic [31:0]     ir_q;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [5:0]      op;
    logic [RA_W-1:0] rc;
    logic            is_alu, is_ld, is_link, writes;
    logic            complete, in_ready, accept;

    assign op = ir_q[31:26];
    assign rc = ir_q[21+RA_W-1:21];

    always_comb begin
        is_alu  = op[5];
        is_ld   = (op == 6'b011000) || (op == 6'b011111);
        is_link = (op == 6'b011011) || (op == 6'b011100) || (op == 6'b011101);
        writes  = is_alu || is_ld || is_link;
    end

    // Everything is gated by rst_n so nothing retires or is accepted while reset is held.
    assign complete = rst_n && (((state_q == StActive) && (!is_ld || bus.mem_rvalid)) ||
                                ((state_q == StWaitMem) && bus.mem_rvalid));
    assign in_ready = rst_n && ((state_q == StEmpty) || complete);
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.rf_we     = complete && writes && (rc != RA_W'(ZERO_REG));
    assign bus.rf_w_addr = rc;
    assign bus.ir_next   = ir_q;
    assign bus.busy      = (state_q != StEmpty);
    assign bus.mem_err   = (state_q == StErr);

    always_comb begin
        bus.rf_w_data = '0;
        if (bus.rf_we) begin
            if (is_alu)     bus.rf_w_data = y_q;
            else if (is_ld) bus.rf_w_data = bus.mem_rdata;
            else            bus.rf_w_data = pc_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            StEmpty: begin
                if (accept) state_d = StActive;
            end
            StActive, StWaitMem: begin
                if (complete) begin
                    state_d    = accept ? StActive : StEmpty;
                    wait_cnt_d = '0;
                end else if (state_q == StActive) begin
                    state_d    = StWaitMem;
                    wait_cnt_d = CW'(1);
                end else if (wait_cnt_q == CW'(MAX_WAIT)) begin
                    state_d = StErr;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = StErr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            wait_cnt_q <= '0;
            pc_q       <= '0;
            ir_q       <= '0;
            y_q        <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (accept) begin
                pc_q <= bus.pc;
                ir_q <= bus.ir;
                y_q  <= bus.y;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n)        retire_cnt_q <= '0;
        else if (complete) retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign retire_cnt = retire_cnt_q;
`endif
endmodule
